pipeline_stall_ctrl: RTL and testbench



---
 rtl/pipeline_stall_ctrl_pkg.sv | 23 ++
 rtl/pipeline_stall_ctrl_if.sv | 39 +++
 rtl/pipeline_stall_ctrl_load_use_detect.sv | 25 ++
 rtl/pipeline_stall_ctrl.sv | 114 +++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: FP op encodings,
// the controller state type and default FP latencies.
package pipeline_pkg;

  localparam logic [1:0] FP_OP_NONE = 2'b00;
  localparam logic [1:0] FP_OP_MUL  = 2'b01;
  localparam logic [1:0] FP_OP_DIV  = 2'b10;

  localparam int FP_MUL_CYCLES_DEF = 4;
  localparam int FP_DIV_CYCLES_DEF = 10;
  localparam int CNT_W_DEF         = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    FP_BUSY = 1'b1
  } state_t;

  // Only mul and div occupy EX for more than one cycle; 11 behaves like 00.
  function automatic logic is_multi_cycle(input logic [1:0] op);
    return (op == FP_OP_MUL) || (op == FP_OP_DIV);
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs from ID/EX and the register-control outputs of the stall
// controller, bundled as one interface.
interface pipeline_stall_ctrl_if;

  logic [4:0]  rs1Id;
  logic [4:0]  rs2Id;
  logic        useRs1Id;
  logic        useRs2Id;
  logic        memReadEx;
  logic [4:0]  rWEx;
  logic        fpStartEx;
  logic [1:0]  fpOpEx;
  logic        branchTakenEx;

  logic        pcWrite;
  logic        ifIdWrite;
  logic        idExWrite;
  logic        idExBubble;
  logic        ifIdFlush;
  logic        fpBusy;
  logic [15:0] stallCycles;

  // Pipeline side: presents the instruction fields, consumes the controls.
  modport master (
    output rs1Id, rs2Id, useRs1Id, useRs2Id, memReadEx, rWEx,
           fpStartEx, fpOpEx, branchTakenEx,
    input  pcWrite, ifIdWrite, idExWrite, idExBubble, ifIdFlush,
           fpBusy, stallCycles
  );

  // Controller side.
  modport slave (
    input  rs1Id, rs2Id, useRs1Id, useRs2Id, memReadEx, rWEx,
           fpStartEx, fpOpEx, branchTakenEx,
    output pcWrite, ifIdWrite, idExWrite, idExBubble, ifIdFlush,
           fpBusy, stallCycles
  );

endinterface

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// Combinational load-use comparator: flags when the ID instruction reads the
// register that the load currently in EX will write. x0 never creates a hazard.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] rs1Id,
  input  logic [4:0] rs2Id,
  input  logic       useRs1Id,
  input  logic       useRs2Id,
  input  logic       memReadEx,
  input  logic [4:0] rWEx,
  output logic       hazard
);

  logic rs1_match;
  logic rs2_match;

  // Compare each used source operand against the load destination.
  always_comb begin
    rs1_match = useRs1Id && (rs1Id == rWEx);
    rs2_match = useRs2Id && (rs2Id == rWEx);
    hazard    = memReadEx && (rWEx != 5'd0) && (rs1_match || rs2_match);
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: produces PC / IF/ID / ID/EX write enables, the
// ID/EX bubble and IF/ID flush. Handles taken branches, multi-cycle FP ops in
// EX and load-use hazards, and counts stalled cycles (saturating).
module pipeline_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int FP_MUL_CYCLES = FP_MUL_CYCLES_DEF,
  parameter int FP_DIV_CYCLES = FP_DIV_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_stall_ctrl_if.slave bus
);

  // The cycle that launches the op and the release cycle are not counted by
  // cnt, hence the -2.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(FP_MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(FP_DIV_CYCLES - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      stall_q, stall_d;

  logic load_use;
  logic pc_we, ifid_we, idex_we, bubble, flush;

  load_use_detect u_load_use_detect (
    .rs1Id     (bus.rs1Id),
    .rs2Id     (bus.rs2Id),
    .useRs1Id  (bus.useRs1Id),
    .useRs2Id  (bus.useRs2Id),
    .memReadEx (bus.memReadEx),
    .rWEx      (bus.rWEx),
    .hazard    (load_use)
  );

  // Next-state and control outputs; priority in IDLE is branch > FP > load-use.
  always_comb begin
    pc_we   = 1'b1;
    ifid_we = 1'b1;
    idex_we = 1'b1;
    bubble  = 1'b0;
    flush   = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;

    if (reset) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.branchTakenEx) begin
            flush  = 1'b1;
            bubble = 1'b1;
          end else if (bus.fpStartEx && is_multi_cycle(bus.fpOpEx)) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            idex_we = 1'b0;
            state_d = FP_BUSY;
            cnt_d   = (bus.fpOpEx == FP_OP_DIV) ? DIV_LOAD : MUL_LOAD;
          end else if (load_use) begin
            // The load leaves EX next edge, so a single bubble resolves it.
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            bubble  = 1'b1;
          end
        end
        FP_BUSY: begin
          // EX still presents the FP op here, so its inputs are not events.
          if (cnt_q != '0) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            idex_we = 1'b0;
            cnt_d   = cnt_q - 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Saturating stall counter update.
  always_comb begin
    stall_d = stall_q;
    if (reset) begin
      stall_d = '0;
    end else if (!pc_we && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // State, latency counter and stall counter registers.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    stall_q <= stall_d;
  end

  assign bus.pcWrite     = pc_we;
  assign bus.ifIdWrite   = ifid_we;
  assign bus.idExWrite   = idex_we;
  assign bus.idExBubble  = bubble;
  assign bus.ifIdFlush   = flush;
  assign bus.fpBusy      = (state_q == FP_BUSY);
  assign bus.stallCycles = stall_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_stall_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 10;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipeline_stall_ctrl_if bus ();

  pipeline_stall_ctrl #(
    .FP_MUL_CYCLES (MUL_LAT),
    .FP_DIV_CYCLES (DIV_LAT),
    .CNT_W         (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // m_busy: number of upcoming cycles (including the current one) in which
  // the FP unit still holds EX; the last of them is the release cycle.
  int m_busy  = 0;
  int m_stall = 0;
  bit m_valid = 0;
  logic e_pc, e_ifid, e_idex, e_bub, e_fl;
  bit   haz, start;
  int   lat;

  always @(negedge clk) begin
    e_pc = 1; e_ifid = 1; e_idex = 1; e_bub = 0; e_fl = 0;
    start = 0; lat = 0;
    haz = bus.memReadEx && (bus.rWEx != 0) &&
          ((bus.useRs1Id && bus.rs1Id == bus.rWEx) ||
           (bus.useRs2Id && bus.rs2Id == bus.rWEx));
    if (!reset) begin
      if (m_busy > 0) begin
        if (m_busy > 1) begin e_pc = 0; e_ifid = 0; e_idex = 0; end
      end else if (bus.branchTakenEx) begin
        e_fl = 1; e_bub = 1;
      end else if (bus.fpStartEx && (bus.fpOpEx == 2'b01 || bus.fpOpEx == 2'b10)) begin
        e_pc = 0; e_ifid = 0; e_idex = 0;
        start = 1;
        lat = (bus.fpOpEx == 2'b10) ? DIV_LAT : MUL_LAT;
      end else if (haz) begin
        e_pc = 0; e_ifid = 0; e_bub = 1;
      end
    end

    if (m_valid) begin
      chk("pcWrite",     bus.pcWrite,     e_pc);
      chk("ifIdWrite",   bus.ifIdWrite,   e_ifid);
      chk("idExWrite",   bus.idExWrite,   e_idex);
      chk("idExBubble",  bus.idExBubble,  e_bub);
      chk("ifIdFlush",   bus.ifIdFlush,   e_fl);
      chk("fpBusy",      bus.fpBusy,      (m_busy > 0) ? 1 : 0);
      chk("stallCycles", bus.stallCycles, m_stall);
    end

    if (reset) begin
      m_busy  = 0;
      m_stall = 0;
      m_valid = 1;
    end else begin
      if (m_busy > 0) m_busy--;
      else if (start) m_busy = lat - 1;
      if (!e_pc && m_stall < 65535) m_stall++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.rs1Id = 0; bus.rs2Id = 0; bus.useRs1Id = 0; bus.useRs2Id = 0;
    bus.memReadEx = 0; bus.rWEx = 0; bus.fpStartEx = 0; bus.fpOpEx = 0;
    bus.branchTakenEx = 0;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_pcWrite", bus.pcWrite, 1);
    chk("rst_stall",   bus.stallCycles, 0);
    chk("rst_fpBusy",  bus.fpBusy, 0);
    tick();

    // Load-use on rs2
    bus.memReadEx = 1; bus.rWEx = 5; bus.rs2Id = 5; bus.useRs2Id = 1;
    @(negedge clk);
    chk("lu_pc",     bus.pcWrite, 0);
    chk("lu_ifid",   bus.ifIdWrite, 0);
    chk("lu_idex",   bus.idExWrite, 1);
    chk("lu_bubble", bus.idExBubble, 1);
    tick();
    clr();
    @(negedge clk);
    chk("lu_after_pc",     bus.pcWrite, 1);
    chk("lu_after_bubble", bus.idExBubble, 0);
    chk("lu_after_stall",  bus.stallCycles, 1);
    tick();

    // FP multiply: stalled T..T+2, released T+3, busy T+1..T+3
    bus.fpStartEx = 1; bus.fpOpEx = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mul_pc",     bus.pcWrite, (i < 3) ? 0 : 1);
      chk("mul_fpBusy", bus.fpBusy,  (i >= 1) ? 1 : 0);
      tick();
    end
    clr();
    @(negedge clk);
    chk("mul_stall",     bus.stallCycles, 4);
    chk("mul_idle_busy", bus.fpBusy, 0);
    tick();

    // FP divide with branch and load-use noise while busy
    bus.fpStartEx = 1; bus.fpOpEx = 2'b10;
    @(negedge clk);
    chk("div_T_pc", bus.pcWrite, 0);
    tick();
    bus.branchTakenEx = 1; bus.memReadEx = 1; bus.rWEx = 7;
    bus.rs1Id = 7; bus.useRs1Id = 1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("div_pc",     bus.pcWrite, 0);
      chk("div_idex",   bus.idExWrite, 0);
      chk("div_flush",  bus.ifIdFlush, 0);
      chk("div_bubble", bus.idExBubble, 0);
      chk("div_fpBusy", bus.fpBusy, 1);
      tick();
    end
    @(negedge clk);
    chk("div_rel_pc",    bus.pcWrite, 1);
    chk("div_rel_flush", bus.ifIdFlush, 0);
    chk("div_rel_busy",  bus.fpBusy, 1);
    tick();
    clr();
    @(negedge clk);
    chk("div_stall", bus.stallCycles, 13);
    chk("div_idle",  bus.fpBusy, 0);
    tick();

    // Branch beats a simultaneous load-use
    bus.branchTakenEx = 1; bus.memReadEx = 1; bus.rWEx = 3;
    bus.rs1Id = 3; bus.useRs1Id = 1;
    @(negedge clk);
    chk("br_flush",  bus.ifIdFlush, 1);
    chk("br_bubble", bus.idExBubble, 1);
    chk("br_pc",     bus.pcWrite, 1);
    chk("br_ifid",   bus.ifIdWrite, 1);
    tick();
    clr();
    @(negedge clk);
    chk("br_stall", bus.stallCycles, 13);
    tick();

    // Reset in the middle of a divide (cnt = 3)
    bus.fpStartEx = 1; bus.fpOpEx = 2'b10;
    tick();
    clr();
    repeat (5) tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_pc",   bus.pcWrite, 1);
    chk("rstmid_idex", bus.idExWrite, 1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_busy",  bus.fpBusy, 0);
    chk("rstmid_pc2",   bus.pcWrite, 1);
    chk("rstmid_stall", bus.stallCycles, 0);
    tick();
    bus.memReadEx = 1; bus.rWEx = 0; bus.rs1Id = 0; bus.useRs1Id = 1;
    @(negedge clk);
    chk("x0_pc",     bus.pcWrite, 1);
    chk("x0_bubble", bus.idExBubble, 0);
    tick();
    clr();

    // Randomized traffic, checked by the model every cycle
    repeat (1500) begin
      reset             = ($urandom_range(63) == 0);
      bus.rs1Id         = 5'($urandom_range(3));
      bus.rs2Id         = 5'($urandom_range(3));
      bus.rWEx          = 5'($urandom_range(3));
      bus.useRs1Id      = 1'($urandom_range(1));
      bus.useRs2Id      = 1'($urandom_range(1));
      bus.memReadEx     = 1'($urandom_range(1));
      bus.fpStartEx     = ($urandom_range(5) == 0);
      bus.fpOpEx        = 2'($urandom_range(3));
      bus.branchTakenEx = ($urandom_range(7) == 0);
      tick();
    end
    reset = 1'b0;
    clr();
    tick();

    // Saturation of the stall counter
    bus.memReadEx = 1; bus.rWEx = 9; bus.rs2Id = 9; bus.useRs2Id = 1;
    repeat (70000) tick();
    @(negedge clk);
    chk("sat_stall", bus.stallCycles, 65535);
    chk("sat_pc",    bus.pcWrite, 0);
    tick();
    clr();
    @(negedge clk);
    chk("sat_hold", bus.stallCycles, 65535);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
